// File: rtl/bb_pkg.sv
// Shared types for the move-generation bitboard pipeline.
//   BB_W / SQ_W  : bitboard width and square-index width
//   bitboard_t   : one bitboard, bit n = square n
//   square_t     : binary square index
//   iter_state_t : bitboard iterator control states
package bb_pkg;
    localparam int BB_W = 64;
    localparam int SQ_W = 6;

    typedef logic [BB_W-1:0] bitboard_t;
    typedef logic [SQ_W-1:0] square_t;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } iter_state_t;
endpackage

// File: rtl/onehot_to_index.sv
// One-hot to binary encoder built as an OR tree.
//   onehot : WIDTH-bit input, at most one bit set
//   idx    : binary index of the set bit (0 when onehot is all-zero)
// Index bit b is the OR of every input bit whose position has bit b set,
// so no priority chain is needed; the result is only meaningful when the
// input really is one-hot.
module onehot_to_index #(
    parameter int WIDTH = 64,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] onehot,
    output logic [IDXW-1:0]  idx
);
    genvar gi, gj;
    generate
        for (gi = 0; gi < IDXW; gi++) begin : g_bit
            logic [WIDTH-1:0] terms;
            for (gj = 0; gj < WIDTH; gj++) begin : g_term
                if (((gj >> gi) % 2) == 1) begin : g_on
                    assign terms[gj] = onehot[gj];
                end else begin : g_off
                    assign terms[gj] = 1'b0;
                end
            end
            assign idx[gi] = |terms;
        end
    endgenerate
endmodule

// File: rtl/bitboard_iter.sv
// Sequential square iterator: takes one bitboard per transaction and emits
// its set squares lowest-first, one per cycle.
//   clk, rst          : clock, asynchronous active-high reset
//   in_valid/in_ready : bitboard load handshake, in_bits = bitboard
//   out_valid/out_ready : per-square beat handshake
//   out_sel           : one-hot mask of the current square (0 on empty beat)
//   out_idx           : binary square index (0 on empty beat)
//   out_seq           : ordinal of this beat within the bitboard
//   out_last          : final beat of the bitboard
//   out_empty         : the bitboard was zero; single beat, no square
//   flush             : synchronous abort of the current bitboard
module bitboard_iter
    import bb_pkg::*;
#(
    parameter int WIDTH = BB_W,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bits,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sel,
    output logic [IDXW-1:0]  out_idx,
    output logic [IDXW:0]    out_seq,
    output logic             out_last,
    output logic             out_empty,
    input  logic             flush
);
    iter_state_t      state_reg, state_next;
    logic [WIDTH-1:0] rem_reg, rem_next;
    logic [IDXW:0]    seq_reg, seq_next;
    logic             empty_reg, empty_next;

    logic             scan;
    logic [WIDTH-1:0] rem_dec;
    logic [WIDTH-1:0] low_bit;
    logic [WIDTH-1:0] rem_rest;
    logic [IDXW-1:0]  low_idx;
    logic             out_fire;
    logic             in_fire;

    assign scan = (state_reg == SCAN);

    // Lowest set bit isolation: x & ~(x-1) keeps only the lowest one,
    // x & (x-1) drops it. Both share the single decrement.
    assign rem_dec  = rem_reg - WIDTH'(1);
    assign low_bit  = rem_reg & ~rem_dec;
    assign rem_rest = rem_reg & rem_dec;

    onehot_to_index #(
        .WIDTH (WIDTH),
        .IDXW  (IDXW)
    ) u_enc (
        .onehot (low_bit),
        .idx    (low_idx)
    );

    // Outputs are gated by SCAN so that IDLE always shows reset values,
    // regardless of what the counter held when the last bitboard ended.
    assign out_valid = scan;
    assign out_sel   = scan ? low_bit : '0;
    assign out_idx   = scan ? low_idx : '0;
    assign out_seq   = scan ? seq_reg : '0;
    assign out_empty = scan && empty_reg;
    assign out_last  = scan && (empty_reg || (rem_rest == '0));

    assign out_fire = out_valid && out_ready;
    // Combinational out_ready -> in_ready path lets a new bitboard load on
    // the last-beat handshake, giving gap-free back-to-back operation.
    assign in_ready = !flush && (!scan || (out_fire && out_last));
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        state_next = state_reg;
        rem_next   = rem_reg;
        seq_next   = seq_reg;
        empty_next = empty_reg;
        if (flush) begin
            state_next = IDLE;
            rem_next   = '0;
            seq_next   = '0;
            empty_next = 1'b0;
        end else begin
            if (out_fire) begin
                rem_next = rem_rest;
                seq_next = seq_reg + (IDXW+1)'(1);
                if (out_last) begin
                    state_next = IDLE;
                end
            end
            // A load accepted on the last beat overrides the return to IDLE.
            if (in_fire) begin
                state_next = SCAN;
                rem_next   = in_bits;
                seq_next   = '0;
                empty_next = (in_bits == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            rem_reg   <= '0;
            seq_reg   <= '0;
            empty_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            rem_reg   <= rem_next;
            seq_reg   <= seq_next;
            empty_reg <= empty_next;
        end
    end
endmodule

// File: doc/bitboard_iter.md
# bitboard_iter

Sequential square iterator for move generation. Accepts one 64-bit bitboard per transaction and emits its set squares one per cycle, lowest square first, as a one-hot mask plus a 6-bit square index. It sits directly downstream of attack/occupancy mask generation and feeds the per-square move-emission stage. Full valid/ready handshake on both sides; sustains one square per cycle under no back-pressure.

## Interface

- `WIDTH`, default 64: bitboard width in bits; must be a power of two ≥ 2.
- `IDXW`, default `$clog2(WIDTH)` (= 6): square index width.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `in_valid`  in  1: `in_bits` holds a bitboard to iterate.
- `in_ready`  out  1: iterator can accept a bitboard this cycle.
- `in_bits`  in  WIDTH: bitboard; bit n is square n.
- `out_valid`  out  1: an output beat is presented.
- `out_ready`  in  1: consumer takes the beat this cycle.
- `out_sel`  out  WIDTH: one-hot mask of the current square; all-zero on the empty beat.
- `out_idx`  out  IDXW: binary index of the set bit in `out_sel`; 0 on the empty beat.
- `out_seq`  out  IDXW+1: ordinal of this beat within the bitboard, counting from 0.
- `out_last`  out  1: final beat of the current bitboard.
- `out_empty`  out  1: the bitboard was zero; the beat carries no square.
- `flush`  in  1: synchronous abort of the current bitboard.

## Operation

- States: `IDLE`, `SCAN`. State register `rem[WIDTH-1:0]`, counter `seq`, flag `empty_q`.
- IDLE: `in_ready`=1, `out_valid`=0. On `in_valid && in_ready`: `rem <= in_bits`, `seq <= 0`, `empty_q <= (in_bits==0)`, go to SCAN.
- SCAN: `out_valid`=1.
  - `out_sel = rem & ~(rem - 1)`, computed modulo 2^WIDTH.
  - `out_idx` is the binary encoding of `out_sel`.
  - `out_last = empty_q || (rem & (rem-1)) == 0`.
  - `out_empty = empty_q`.
  - `out_seq = seq`.
- On `out_valid && out_ready` in SCAN:
  - `rem <= rem & (rem-1)`, `seq <= seq+1`.
  - If `out_last`, go to IDLE, unless a new load is accepted in the same cycle (below).
- Back-to-back: `in_ready = (state==IDLE) || (out_valid && out_ready && out_last)`. A load accepted on the last-beat handshake goes straight back to SCAN with the new `rem`. This is a combinational `out_ready`→`in_ready` path, and that path is intentional.
- Zero bitboard: produces exactly one beat with `out_empty`=1, `out_last`=1, `out_sel`=0, `out_idx`=0, `out_seq`=0.
- Back-pressure: while `out_valid && !out_ready`, all `out_*` are held stable.
- `flush`: has priority over everything else. Next state is IDLE; `rem`, `seq` and `empty_q` clear; no load is accepted that cycle (`in_ready` forced 0 while `flush`=1); the current beat is discarded even if handshaken.
- Reset (asynchronous, any time, including mid-SCAN): state IDLE, `rem`=0, `seq`=0, `empty_q`=0.
  - Outputs after reset: `out_valid`=0, `out_sel`=0, `out_idx`=0, `out_seq`=0, `out_last`=0, `out_empty`=0, `in_ready`=1.
  - While `rst` is high, handshakes have no effect.

## Timing

- Load latency: a bitboard accepted at edge N presents its first beat from cycle N+1.
- Throughput: one square per cycle with `out_ready` held at 1. A bitboard with k set bits (k≥1) occupies SCAN for exactly k cycles; a zero bitboard occupies it for 1 cycle.
- With back-to-back loads there are no idle cycles between bitboards.
- All outputs are combinational from registers only, except `in_ready`, which also depends on `out_ready`.
- Critical path: the WIDTH-bit decrement plus the one-hot→binary encoder; the design must close at the project clock with WIDTH=64.

## Structure

- Shared package `bb_pkg`:
  - `BB_W`=64 and `SQ_W`=6.
  - typedef `bitboard_t` (`logic [BB_W-1:0]`) and `square_t` (`logic [SQ_W-1:0]`).
  - enum `iter_state_t {IDLE, SCAN}`.
- One sub-module, `onehot_to_index`, parameterized by WIDTH: pure combinational OR-tree encoder, reused by later stages. Lowest-bit isolation stays inline.

## Test plan

- Load `0x8000_0000_0000_0001`, `out_ready`=1 → two beats: idx 0 (seq 0, last 0), then idx 63 (seq 1, last 1); `in_ready` high again on the second beat.
- Load `0` → one beat with `out_empty`=1, `out_last`=1, `out_sel`=0, `out_idx`=0; next cycle IDLE.
- Load `0xFFFF_FFFF_FFFF_FFFF`, `out_ready`=1 → 64 consecutive beats, idx 0..63, seq 0..63, `out_last` only on idx 63.
- Load `0x0000_0000_0010_0400`, hold `out_ready`=0 for 3 cycles → idx 10 held stable; then idx 10, idx 20 (last).
- Back-to-back: `0x1` then `0x6` presented continuously → beats idx 0 (last), idx 1, idx 2 (last) in 3 consecutive cycles.
- Load `0xF0`, assert `flush` after the idx 4 beat (and separately, `rst` mid-SCAN) → no further beats; outputs return to reset values; next load `0x2` yields a single beat, idx 1.
